// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, DATA_BITS LSB first, optional even parity, one stop bit.
// serial_out is registered and idles high; tx_busy covers the whole frame.
module uart_tx_block #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 serial_reg, serial_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 bit_end;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      serial_reg <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      serial_reg <= serial_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign bit_end = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    serial_next = serial_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    // Every non-idle state times one bit period with the same counter.
    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          state_next  = START;
          shift_next  = tx_data;
          parity_next = ^tx_data;
          busy_next   = 1'b1;
          serial_next = 1'b0;
          cnt_next    = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next  = DATA;
          serial_next = shift_reg[0];
          shift_next  = shift_reg >> 1;
          idx_next    = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_reg == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              state_next  = PARITY;
              serial_next = parity_reg;
            end else begin
              state_next  = STOP;
              serial_next = 1'b1;
            end
          end else begin
            idx_next    = idx_reg + 1'b1;
            serial_next = shift_reg[0];
            shift_next  = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next  = STOP;
          serial_next = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next  = IDLE;
          serial_next = 1'b1;
          busy_next   = 1'b0;
          done_next   = 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
        busy_next   = 1'b0;
      end
    endcase
  end

  assign serial_out = serial_reg;
  assign tx_busy    = busy_reg;
  assign tx_done    = done_reg;

endmodule
